// File: rtl/shift_pkg.sv
// Shared definitions for the shift-register serial link receive path.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Bit order of the serial stream; the MSBFirst pin carries this encoding.
    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } shift_dir_t;

endpackage

// File: rtl/deser_out_buf.sv
// One-entry valid/ready output register for the deserializer.
// accept_ok tells the shifter whether a word completing this cycle can be
// stored (buffer empty, or being drained in the same cycle).
module deser_out_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             word_ready,
    output logic [WIDTH-1:0] Q,
    output logic             word_valid,
    output logic             accept_ok
);

    logic [WIDTH-1:0] r_q;
    logic             r_valid;

    assign accept_ok  = !r_valid || word_ready;
    assign Q          = r_q;
    assign word_valid = r_valid;

    // Load a new word when there is room, otherwise drain on handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q     <= '0;
            r_valid <= 1'b0;
        end else if (load && accept_ok) begin
            r_q     <= data;
            r_valid <= 1'b1;
        end else if (r_valid && word_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver: assembles WIDTH-bit words one qualified
// bit at a time, MSB-first or LSB-first chosen per bit, and hands completed
// words to a one-entry valid/ready buffer. A word that completes while the
// buffer is full and not being drained is dropped and flagged in overrun.
module shift_deserializer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             MSBFirst,
    input  logic             clear,
    input  logic             word_ready,
    output logic [WIDTH-1:0] Q,
    output logic             word_valid,
    output logic             overrun,
    output logic [CW-1:0]    bit_count
);

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_count;
    logic             r_overrun;

    logic [WIDTH-1:0] w_shifted;
    logic             w_accept;
    logic             w_last;
    logic             w_complete;
    logic             w_accept_ok;
    shift_dir_t       w_dir;

    assign w_dir      = shift_dir_t'(MSBFirst);
    assign w_accept   = bit_valid && !clear;
    assign w_last     = (r_count == LAST_BIT);
    assign w_complete = w_accept && w_last;

    // Next shift-register value including the incoming bit.
    always_comb begin
        w_shifted = r_sreg;
        if (w_dir == MSB_FIRST) begin
            w_shifted = {r_sreg[WIDTH-2:0], serial_in};
        end else begin
            w_shifted = {serial_in, r_sreg[WIDTH-1:1]};
        end
    end

    // Shift register, bit counter and sticky overrun; clear aborts the word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sreg    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else if (clear) begin
            r_sreg    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sreg  <= w_shifted;
                r_count <= w_last ? '0 : r_count + 1'b1;
            end
            if (w_complete && !w_accept_ok) begin
                r_overrun <= 1'b1;
            end
        end
    end

    deser_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clock      (clock),
        .reset      (reset),
        .load       (w_complete),
        .data       (w_shifted),
        .word_ready (word_ready),
        .Q          (Q),
        .word_valid (word_valid),
        .accept_ok  (w_accept_ok)
    );

    assign overrun   = r_overrun;
    assign bit_count = r_count;

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: arithmetic reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_shift_deserializer;

    localparam int W  = 4;
    localparam int CW = $clog2(W);

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         serial_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         MSBFirst = 1'b1;
    logic         clear = 1'b0;
    logic         word_ready = 1'b0;
    logic [W-1:0] Q;
    logic         word_valid;
    logic         overrun;
    logic [CW-1:0] bit_count;

    int n_vec = 0;
    int n_err = 0;

    shift_deserializer #(.WIDTH(W), .CW(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .MSBFirst   (MSBFirst),
        .clear      (clear),
        .word_ready (word_ready),
        .Q          (Q),
        .word_valid (word_valid),
        .overrun    (overrun),
        .bit_count  (bit_count)
    );

    always #5 clock = ~clock;

    // Reference model: word value as an integer, bits collected as a count.
    int m_sreg = 0;
    int m_cnt  = 0;
    int m_q    = 0;
    int m_v    = 0;
    int m_ovr  = 0;

    always @(posedge clock or negedge reset) begin
        int room;
        int done;
        if (!reset) begin
            m_sreg = 0; m_cnt = 0; m_q = 0; m_v = 0; m_ovr = 0;
        end else begin
            room = (m_v == 0 || word_ready) ? 1 : 0;
            done = 0;
            if (clear) begin
                m_sreg = 0; m_cnt = 0; m_ovr = 0;
            end else if (bit_valid) begin
                if (MSBFirst)
                    m_sreg = (m_sreg * 2 + int'(serial_in)) % (1 << W);
                else
                    m_sreg = m_sreg / 2 + int'(serial_in) * (1 << (W - 1));
                if (m_cnt == W - 1) begin
                    m_cnt = 0;
                    done  = 1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (done != 0) begin
                if (room != 0) begin
                    m_q = m_sreg;
                    m_v = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (m_v != 0 && word_ready) begin
                m_v = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (reset) begin
            n_vec = n_vec + 4;
            if (int'(Q) != m_q) begin
                n_err++;
                $display("FAIL model_Q t=%0t got=%b want=%b", $time, Q, m_q[W-1:0]);
            end
            if (int'(word_valid) != m_v) begin
                n_err++;
                $display("FAIL model_word_valid t=%0t got=%0d want=%0d", $time, word_valid, m_v);
            end
            if (int'(overrun) != m_ovr) begin
                n_err++;
                $display("FAIL model_overrun t=%0t got=%0d want=%0d", $time, overrun, m_ovr);
            end
            if (int'(bit_count) != m_cnt) begin
                n_err++;
                $display("FAIL model_bit_count t=%0t got=%0d want=%0d", $time, bit_count, m_cnt);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
        end else begin
            $display("check %s t=%0t value=%0d ok", name, $time, act);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge.
    task automatic cyc(input logic bv, input logic sin, input logic msb,
                       input logic clr, input logic rdy);
        @(negedge clock);
        #1;
        bit_valid  = bv;
        serial_in  = sin;
        MSBFirst   = msb;
        clear      = clr;
        word_ready = rdy;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, MSBFirst, 1'b0, rdy);
    endtask

    task automatic send4(input logic [W-1:0] bits, input logic msb, input logic rdy);
        for (int i = W - 1; i >= 0; i--) cyc(1'b1, bits[i], msb, 1'b0, rdy);
    endtask

    initial begin
        // Asynchronous reset assertion, checked before any clock edge.
        #2 reset = 1'b0;
        #1;
        chk("reset_Q", int'(Q), 0);
        chk("reset_word_valid", int'(word_valid), 0);
        chk("reset_overrun", int'(overrun), 0);
        chk("reset_bit_count", int'(bit_count), 0);
        @(negedge clock); #1 reset = 1'b1;

        // MSB-first 1,0,1,1 -> 1011 (first bit sent is listed leftmost).
        send4(4'b1011, 1'b1, 1'b0);
        idle(1'b0);
        chk("msb_Q", int'(Q), 11);
        chk("msb_word_valid", int'(word_valid), 1);
        chk("msb_bit_count", int'(bit_count), 0);

        // Drain, then LSB-first 1,0,1,1 -> 1101.
        idle(1'b1);
        send4(4'b1011, 1'b0, 1'b0);
        idle(1'b0);
        chk("lsb_Q", int'(Q), 13);
        idle(1'b1);
        idle(1'b0);
        chk("drain_word_valid", int'(word_valid), 0);
        chk("drain_Q_held", int'(Q), 13);

        // Overrun: hold 1011, send 0,1,1,0 with no ready.
        send4(4'b1011, 1'b1, 1'b0);
        send4(4'b0110, 1'b1, 1'b0);
        idle(1'b0);
        chk("ovr_overrun", int'(overrun), 1);
        chk("ovr_Q_kept", int'(Q), 11);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        chk("clr_overrun", int'(overrun), 0);
        chk("clr_word_valid", int'(word_valid), 1);

        // Simultaneous accept and complete: 0011 held, 1100 arrives with ready.
        idle(1'b1);
        send4(4'b0011, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        chk("simul_Q", int'(Q), 12);
        chk("simul_word_valid", int'(word_valid), 1);
        chk("simul_overrun", int'(overrun), 0);

        // Abort with clear+bit_valid, then a gapped word 0,1,0,1.
        idle(1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b0);
        chk("abort_bit_count", int'(bit_count), 0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("gap_bit_count_hold", int'(bit_count), 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("gap_Q", int'(Q), 5);
        chk("gap_word_valid", int'(word_valid), 1);

        // Mid-word asynchronous reset while a word is held.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("pre_reset_bit_count", int'(bit_count), 3);
        #1 reset = 1'b0;
        #1;
        chk("async_Q", int'(Q), 0);
        chk("async_word_valid", int'(word_valid), 0);
        chk("async_bit_count", int'(bit_count), 0);
        @(negedge clock); #1 reset = 1'b1;
        send4(4'b1110, 1'b1, 1'b0);
        idle(1'b0);
        chk("post_reset_Q", int'(Q), 14);
        chk("post_reset_word_valid", int'(word_valid), 1);

        // Full-rate back-to-back words with ready tied high.
        send4(4'b1001, 1'b1, 1'b1);
        send4(4'b0110, 1'b0, 1'b1);
        idle(1'b1);
        chk("b2b_Q", int'(Q), 6);
        chk("b2b_overrun", int'(overrun), 0);
        idle(1'b0);
        idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
